// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared FSM encoding and IEEE-754 constants for the divider arbiter
package fp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam int          DEFAULT_TIMEOUT = 64;
  localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
  localparam logic [7:0]  FP_INF_EXP      = 8'hFF;

  // True for +0 and -0 divisors; those skip the divider entirely.
  function automatic logic is_zero_mag(input logic [31:0] f);
    return f[30:0] == 31'h0;
  endfunction

  function automatic logic [31:0] signed_inf(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], FP_INF_EXP, 23'h0};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; last names the port granted most recently
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - shares one FP divider between two requesters, with
// divide-by-zero bypass and a bounded wait for the divider result.
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  done,
  output logic [31:0] result,
  output logic        err,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_c,
  input  logic        div_ready
);

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q,  state_d;
  logic          winner_q, winner_d;
  logic          last_q,   last_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [31:0]   result_q, result_d;
  logic          err_q,    err_d;
  logic [31:0]   div_a_q,  div_a_d;
  logic [31:0]   div_b_q,  div_b_d;

  logic [1:0]    gnt;
  logic          win_idx;
  logic [31:0]   win_a;
  logic [31:0]   win_b;
  logic          win_bypass;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  assign win_idx    = gnt[1];
  assign win_a      = win_idx ? a1 : a0;
  assign win_b      = win_idx ? b1 : b0;
  assign win_bypass = is_zero_mag(win_b);

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    err_d     = err_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    div_start = 1'b0;
    done      = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // A zero divisor never touches the divider, so it need not wait for it.
        if (gnt != 2'b00 && (win_bypass || div_ready)) begin
          winner_d = win_idx;
          div_a_d  = win_a;
          div_b_d  = win_b;
          if (win_bypass) begin
            result_d = signed_inf(win_a, win_b);
            err_d    = 1'b0;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        div_start = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        // div_ready may still reflect the idle divider here; skip it.
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_ready) begin
          result_d = div_c;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = FP_QNAN;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        done    = winner_q ? 2'b10 : 2'b01;
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
      div_a_q  <= 32'h0;
      div_b_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign result = result_q;
  assign err    = err_q;
  assign div_a  = div_a_q;
  assign div_b  = div_b_q;

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles waited for div_ready per operation.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  per-requester request level; bit i = port i.
REQ-005 a0, b0  input  32 each  port 0 operands A (dividend), B (divisor), IEEE-754 single.
REQ-006 a1, b1  input  32 each  port 1 operands.
REQ-007 done  output  2  one-cycle completion pulse, one-hot to granted port.
REQ-008 result  output  32  quotient A/B, valid only while done != 0.
REQ-009 err  output  1  timeout flag, valid only while done != 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 div_start  output  1  one-cycle start pulse to shared divider.
REQ-012 div_a, div_b  output  32 each  registered operands to divider.
REQ-013 div_c  input  32  divider quotient.
REQ-014 div_ready  input  1  divider idle/result-valid level.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, SETTLE, WAIT, RESP.
REQ-016 IDLE: grant only when req != 0; a divider grant also requires div_ready=1; the bypass path (REQ-021) does not.
REQ-017 Arbitration SHALL be round-robin: if both req bits are set, the port not granted last wins; a single requester wins immediately.
REQ-018 On grant, operands of the winner SHALL be latched into div_a/div_b and the winner index stored; next state ISSUE.
REQ-019 ISSUE: div_start=1 for exactly one cycle; next SETTLE.
REQ-020 SETTLE: div_ready ignored for one cycle; next WAIT with timeout counter cleared.
REQ-021 Bypass: if the winner's b[30:0]==0, no div_start is issued; go IDLE->RESP with result {a[31]^b[31], 8'hFF, 23'h0}, err=0.
REQ-022 WAIT: on div_ready=1, capture div_c into result, err=0, go RESP.
REQ-023 WAIT: if the counter reaches TIMEOUT-1 with div_ready=0, set result=32'h7FC00000 and err=1, go RESP.
REQ-024 RESP: done[winner]=1 for exactly one cycle; last-grant pointer updated to winner; next IDLE.
REQ-025 Divider latency: done rises 4+k cycles after the grant cycle, where k = WAIT cycles spent; bypass done is 1 cycle after grant.
REQ-026 Requesters SHALL hold req and operands stable until their done; operand changes after grant are ignored.
REQ-027 Dropping req after grant SHALL NOT abort the operation; done still pulses.
REQ-028 A port whose req is still high in the RESP cycle is re-eligible in the following IDLE cycle, subject to round-robin.
REQ-029 At most one operation in flight; done is never asserted on both bits.

Reset
REQ-030 On rst: state=IDLE; done=0, result=0, err=0, busy=0, div_start=0, div_a=0, div_b=0; counter=0; last-grant pointer=1, so port 0 wins first.
REQ-031 Reset mid-operation SHALL discard the operation with no done; the next divider grant waits for div_ready=1.

Structure
REQ-032 Shared package fp_div_pkg SHALL hold the state encoding, default TIMEOUT, and constants FP_QNAN=32'h7FC00000 and FP_INF_EXP=8'hFF.
REQ-033 The round-robin grant logic SHALL be sub-module rr_arb2 (2 requests, pointer input, one-hot grant output).

Verification
REQ-034 Single request: req=01, a0=40C00000 (6.0), b0=40000000 (2.0), model ready 5 cycles after start -> one div_start, done=01, result=40400000, err=0.
REQ-035 Contention: req=11 held for 4 operations -> grant order 0,1,0,1, with exactly one done per operation.
REQ-036 Divide by zero: a1=BF800000, b1=80000000 -> no div_start, done=10 one cycle after grant, result=7F800000.
REQ-037 Timeout: model never raises ready, TIMEOUT=8 -> done pulses with err=1, result=7FC00000, busy then 0.
REQ-038 Reset in WAIT: assert rst -> busy=0, no done; keep div_ready=0 with req=01 -> no grant until div_ready=1.
REQ-039 Stale ready: div_ready held high through ISSUE/SETTLE, model raises it again later -> result captured only in WAIT, never in SETTLE.
